// File: rtl/vend_txn_ctrl.sv
// Coin vending transaction controller: collects credit, runs the dispenser
// req/ack handshake, then pays out change or a refund one unit per acknowledge.
module vend_txn_ctrl #(
    parameter int unsigned PRICE      = 3,
    parameter int unsigned MAX_CREDIT = 7,
    parameter int unsigned CW         = 3,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [1:0]    coin,
    input  logic          cancel,
    input  logic          disp_ack,
    input  logic          change_ack,
    output logic          disp_req,
    output logic          change_req,
    output logic          coin_reject,
    output logic          vend_done,
    output logic [CW-1:0] credit,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [CW:0]   MAX_W     = (CW+1)'(MAX_CREDIT);
    localparam logic [CW:0]   PRICE_W   = (CW+1)'(PRICE);
    localparam logic [CW-1:0] PRICE_CW  = CW'(PRICE);
    localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          vended_q, vended_d;
    logic          coin_reject_q, coin_reject_d;
    logic          vend_done_q, vend_done_d;

    logic [CW:0]   coin_val;
    logic [CW:0]   credit_sum;
    logic          coin_ok;
    logic          coin_fits;
    logic [TW-1:0] tmo_inc;

    // Sum is one bit wider than credit so an overflowing coin is caught, not wrapped.
    always_comb begin
        coin_val = '0;
        if (coin == 2'b01) begin
            coin_val = (CW+1)'(1);
        end else if (coin == 2'b10) begin
            coin_val = (CW+1)'(2);
        end
    end

    assign coin_ok    = coin_valid && ((coin == 2'b01) || (coin == 2'b10));
    assign credit_sum = {1'b0, credit_q} + coin_val;
    assign coin_fits  = (credit_sum <= MAX_W);
    assign tmo_inc    = tmo_cnt_q + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            tmo_cnt_q     <= '0;
            vended_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            vend_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            tmo_cnt_q     <= tmo_cnt_d;
            vended_q      <= vended_d;
            coin_reject_q <= coin_reject_d;
            vend_done_q   <= vend_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        tmo_cnt_d     = tmo_cnt_q;
        vended_d      = vended_q;
        coin_reject_d = 1'b0;
        vend_done_d   = 1'b0;

        case (state_q)
            IDLE, COLLECT: begin
                // Priority in COLLECT: cancel, then an accepted coin, then the timeout.
                if ((state_q == COLLECT) && cancel) begin
                    coin_reject_d = coin_valid;
                    state_d       = CHANGE;
                    vended_d      = 1'b0;
                    tmo_cnt_d     = '0;
                end else if (coin_ok && coin_fits) begin
                    credit_d  = credit_sum[CW-1:0];
                    tmo_cnt_d = '0;
                    state_d   = (credit_sum >= PRICE_W) ? DISPENSE : COLLECT;
                end else begin
                    coin_reject_d = coin_valid;
                    if (state_q == COLLECT) begin
                        if (tmo_inc == TIMEOUT_W) begin
                            state_d   = CHANGE;
                            vended_d  = 1'b0;
                            tmo_cnt_d = '0;
                        end else begin
                            tmo_cnt_d = tmo_inc;
                        end
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_valid;
                if (disp_ack) begin
                    credit_d = credit_q - PRICE_CW;
                    if (credit_q != PRICE_CW) begin
                        state_d  = CHANGE;
                        vended_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        vended_d    = 1'b0;
                        vend_done_d = 1'b1;
                    end
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ack) begin
                    credit_d = credit_q - CW'(1);
                    if (credit_q == CW'(1)) begin
                        state_d     = IDLE;
                        vend_done_d = vended_q;
                        vended_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request outputs decode straight from the state register, so they stay glitch-free.
    assign disp_req    = (state_q == DISPENSE);
    assign change_req  = (state_q == CHANGE);
    assign busy        = (state_q != IDLE);
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign vend_done   = vend_done_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Bench for vend_txn_ctrl: directed scenarios plus a randomized run checked
// against a transaction-level reference model, on two price configurations.
module tb_vend_txn_ctrl;

    localparam int PH_IDLE = 0;
    localparam int PH_COLLECT = 1;
    localparam int PH_DISP = 2;
    localparam int PH_CHANGE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       change_ack = 1'b0;

    logic       disp_req_o[2];
    logic       change_req_o[2];
    logic       coin_reject_o[2];
    logic       vend_done_o[2];
    logic       busy_o[2];
    logic [2:0] credit_o[2];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, one slot per DUT instance
    int m_ph[2];
    int m_cr[2];
    int m_cnt[2];
    int m_vd[2];
    int m_rej[2];
    int m_done[2];
    int p_price[2] = '{3, 7};
    int p_max[2]   = '{7, 7};
    int p_tmo[2]   = '{10, 10};

    always #5 clk = ~clk;

    vend_txn_ctrl #(.PRICE(3), .MAX_CREDIT(7), .CW(3), .TIMEOUT(10), .TW(8)) u_dut_a (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
        .disp_ack(disp_ack), .change_ack(change_ack), .disp_req(disp_req_o[0]),
        .change_req(change_req_o[0]), .coin_reject(coin_reject_o[0]),
        .vend_done(vend_done_o[0]), .credit(credit_o[0]), .busy(busy_o[0])
    );

    vend_txn_ctrl #(.PRICE(7), .MAX_CREDIT(7), .CW(3), .TIMEOUT(10), .TW(8)) u_dut_b (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
        .disp_ack(disp_ack), .change_ack(change_ack), .disp_req(disp_req_o[1]),
        .change_req(change_req_o[1]), .coin_reject(coin_reject_o[1]),
        .vend_done(vend_done_o[1]), .credit(credit_o[1]), .busy(busy_o[1])
    );

    // Transaction-level rules: what one clock edge does to a vending session.
    task automatic model_step(input int k);
        int val;
        m_rej[k]  = 0;
        m_done[k] = 0;
        if (rst) begin
            m_ph[k] = PH_IDLE; m_cr[k] = 0; m_cnt[k] = 0; m_vd[k] = 0;
            return;
        end
        val = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
        if (m_ph[k] == PH_IDLE || m_ph[k] == PH_COLLECT) begin
            if (m_ph[k] == PH_COLLECT && cancel) begin
                m_rej[k] = int'(coin_valid);
                m_ph[k] = PH_CHANGE; m_vd[k] = 0; m_cnt[k] = 0;
            end else if (coin_valid && val > 0 && m_cr[k] + val <= p_max[k]) begin
                m_cr[k] += val;
                m_cnt[k] = 0;
                m_ph[k] = (m_cr[k] >= p_price[k]) ? PH_DISP : PH_COLLECT;
            end else begin
                m_rej[k] = int'(coin_valid);
                if (m_ph[k] == PH_COLLECT) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == p_tmo[k]) begin
                        m_ph[k] = PH_CHANGE; m_cnt[k] = 0; m_vd[k] = 0;
                    end
                end
            end
        end else if (m_ph[k] == PH_DISP) begin
            m_rej[k] = int'(coin_valid);
            if (disp_ack) begin
                m_cr[k] -= p_price[k];
                if (m_cr[k] > 0) begin
                    m_ph[k] = PH_CHANGE; m_vd[k] = 1;
                end else begin
                    m_ph[k] = PH_IDLE; m_done[k] = 1; m_vd[k] = 0;
                end
            end
        end else begin
            m_rej[k] = int'(coin_valid);
            if (change_ack) begin
                m_cr[k]--;
                if (m_cr[k] == 0) begin
                    m_ph[k] = PH_IDLE; m_done[k] = m_vd[k]; m_vd[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic set_in(input logic cv, input logic [1:0] c, input logic can,
                          input logic da, input logic ca);
        coin_valid = cv; coin = c; cancel = can; disp_ack = da; change_ack = ca;
    endtask

    task automatic do_reset();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (credit_o[0] !== 3'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit_o[0]); end
        n_chk++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o[0]); end
        n_chk++; if ({disp_req_o[0], change_req_o[0], coin_reject_o[0], vend_done_o[0]} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outs: got %b want 0000", {disp_req_o[0], change_req_o[0], coin_reject_o[0], vend_done_o[0]});
        end
        $display("test_reset: done");
    endtask

    task automatic test_exact_price();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            tick();
            n_chk++; if (credit_o[0] !== 3'(i)) begin n_fail++; $display("FAIL exact_credit%0d: got %0d want %0d", i, credit_o[0], i); end
            n_chk++; if (disp_req_o[0] !== (i == 3)) begin n_fail++; $display("FAIL exact_dreq%0d: got %0b want %0b", i, disp_req_o[0], i == 3); end
        end
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        n_chk++; if (disp_req_o[0] !== 1'b1) begin n_fail++; $display("FAIL exact_dreq_hold: got %0b want 1", disp_req_o[0]); end
        set_in(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (credit_o[0] !== 3'd0) begin n_fail++; $display("FAIL exact_after_credit: got %0d want 0", credit_o[0]); end
        n_chk++; if (vend_done_o[0] !== 1'b1) begin n_fail++; $display("FAIL exact_done: got %0b want 1", vend_done_o[0]); end
        n_chk++; if (change_req_o[0] !== 1'b0 || disp_req_o[0] !== 1'b0) begin n_fail++; $display("FAIL exact_reqs: got %0b%0b want 00", disp_req_o[0], change_req_o[0]); end
        tick();
        n_chk++; if (vend_done_o[0] !== 1'b0 || change_req_o[0] !== 1'b0) begin n_fail++; $display("FAIL exact_done_pulse: got %0b%0b want 00", vend_done_o[0], change_req_o[0]); end
        $display("test_exact_price: done");
    endtask

    task automatic test_vend_change();
        do_reset();
        set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (credit_o[0] !== 3'd4 || disp_req_o[0] !== 1'b1) begin n_fail++; $display("FAIL chg_disp: got credit %0d dreq %0b want 4 1", credit_o[0], disp_req_o[0]); end
        set_in(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (credit_o[0] !== 3'd1 || change_req_o[0] !== 1'b1 || vend_done_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL chg_enter: got credit %0d creq %0b done %0b want 1 1 0", credit_o[0], change_req_o[0], vend_done_o[0]);
        end
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (credit_o[0] !== 3'd0 || change_req_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL chg_exit: got credit %0d creq %0b busy %0b want 0 0 0", credit_o[0], change_req_o[0], busy_o[0]);
        end
        n_chk++; if (vend_done_o[0] !== 1'b1) begin n_fail++; $display("FAIL chg_done: got %0b want 1", vend_done_o[0]); end
        $display("test_vend_change: done");
    endtask

    task automatic test_cancel();
        do_reset();
        set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        n_chk++; if (change_req_o[0] !== 1'b1 || credit_o[0] !== 3'd2 || disp_req_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL cancel_enter: got creq %0b credit %0d dreq %0b want 1 2 0", change_req_o[0], credit_o[0], disp_req_o[0]);
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
            tick();
            n_chk++; if (credit_o[0] !== 3'(1 - i) || vend_done_o[0] !== 1'b0) begin
                n_fail++; $display("FAIL cancel_refund%0d: got credit %0d done %0b want %0d 0", i, credit_o[0], vend_done_o[0], 1 - i);
            end
        end
        n_chk++; if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL cancel_idle: got busy %0b want 0", busy_o[0]); end
        set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (coin_reject_o[0] !== 1'b1 || credit_o[0] !== 3'd1 || change_req_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL cancel_coin_same: got rej %0b credit %0d creq %0b want 1 1 1", coin_reject_o[0], credit_o[0], change_req_o[0]);
        end
        $display("test_cancel: done");
    endtask

    task automatic test_reject();
        do_reset();
        set_in(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (coin_reject_o[0] !== 1'b1 || credit_o[0] !== 3'd0 || busy_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL rej_code: got rej %0b credit %0d busy %0b want 1 0 0", coin_reject_o[0], credit_o[0], busy_o[0]);
        end
        set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (coin_reject_o[0] !== 1'b1 || credit_o[0] !== 3'd4 || disp_req_o[0] !== 1'b1) begin
            n_fail++; $display("FAIL rej_dispense: got rej %0b credit %0d dreq %0b want 1 4 1", coin_reject_o[0], credit_o[0], disp_req_o[0]);
        end
        do_reset();
        set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        n_chk++; if (credit_o[1] !== 3'd6 || coin_reject_o[1] !== 1'b0) begin n_fail++; $display("FAIL rej_b_six: got credit %0d rej %0b want 6 0", credit_o[1], coin_reject_o[1]); end
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (coin_reject_o[1] !== 1'b1 || credit_o[1] !== 3'd6 || disp_req_o[1] !== 1'b0) begin
            n_fail++; $display("FAIL rej_overflow: got rej %0b credit %0d dreq %0b want 1 6 0", coin_reject_o[1], credit_o[1], disp_req_o[1]);
        end
        tick();
        n_chk++; if (coin_reject_o[1] !== 1'b0) begin n_fail++; $display("FAIL rej_pulse: got %0b want 0", coin_reject_o[1]); end
        $display("test_reject: done");
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_chk++; if (change_req_o[0] !== (i == 10)) begin n_fail++; $display("FAIL tmo_cycle%0d: got creq %0b want %0b", i, change_req_o[0], i == 10); end
        end
        n_chk++; if (credit_o[0] !== 3'd1) begin n_fail++; $display("FAIL tmo_credit: got %0d want 1", credit_o[0]); end
        do_reset();
        set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) set_in(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            tick();
            set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
            n_chk++; if (change_req_o[0] !== (i == 15)) begin n_fail++; $display("FAIL tmo_restart%0d: got creq %0b want %0b", i, change_req_o[0], i == 15); end
        end
        $display("test_timeout: done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (change_req_o[0] !== 1'b1 || credit_o[0] !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre: got creq %0b credit %0d want 1 2", change_req_o[0], credit_o[0]); end
        rst = 1'b1;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        n_chk++; if (credit_o[0] !== 3'd0 || change_req_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || vend_done_o[0] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid: got credit %0d creq %0b busy %0b done %0b want 0 0 0 0", credit_o[0], change_req_o[0], busy_o[0], vend_done_o[0]);
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_random();
        int coin_rate;
        int errs;
        do_reset();
        errs = n_fail;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            coin_rate = (cyc / 500) % 3 + 2;
            rst        = ($urandom_range(0, 299) == 0);
            coin_valid = ($urandom_range(0, coin_rate) == 0);
            coin       = 2'($urandom_range(0, 3));
            cancel     = ($urandom_range(0, 11) == 0);
            disp_ack   = ($urandom_range(0, 2) == 0);
            change_ack = ($urandom_range(0, 1) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (credit_o[k] !== 3'(m_cr[k]) || busy_o[k] !== (m_ph[k] != PH_IDLE) ||
                    disp_req_o[k] !== (m_ph[k] == PH_DISP) || change_req_o[k] !== (m_ph[k] == PH_CHANGE) ||
                    coin_reject_o[k] !== (m_rej[k] != 0) || vend_done_o[k] !== (m_done[k] != 0)) begin
                    n_fail++;
                    $display("FAIL rand_dut%0d cyc %0d: got cr=%0d busy=%0b dreq=%0b creq=%0b rej=%0b done=%0b want cr=%0d ph=%0d rej=%0d done=%0d",
                             k, cyc, credit_o[k], busy_o[k], disp_req_o[k], change_req_o[k], coin_reject_o[k], vend_done_o[k],
                             m_cr[k], m_ph[k], m_rej[k], m_done[k]);
                end
            end
        end
        rst = 1'b0;
        $display("test_random: done, %0d new mismatching cycles", n_fail - errs);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = PH_IDLE; m_cr[k] = 0; m_cnt[k] = 0; m_vd[k] = 0; m_rej[k] = 0; m_done[k] = 0;
        end
        test_reset();
        test_exact_price();
        test_vend_change();
        test_cancel();
        test_reject();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
